// File: rtl/de1_soc_button_pkg.sv
// Shared register map, field positions and event record for the DE1-SoC button event controller.
package de1_soc_button_pkg;

   localparam logic [1:0] REG_EVENT  = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_MASK   = 2'd2;
   localparam logic [1:0] REG_CTRL   = 2'd3;

   localparam int EV_VALID   = 31;
   localparam int EV_PRESS   = 2;
   localparam int ST_OVF     = 16;
   localparam int CTRL_EN    = 0;
   localparam int CTRL_FLUSH = 1;

   localparam int EVENT_W  = 3;
   localparam int NUM_KEYS = 4;

   typedef struct packed {
      logic       press;
      logic [1:0] idx;
   } event_t;

endpackage

// File: rtl/de1_soc_button_debounce.sv
// One push-button: 2-FF synchronizer on the inverted key, stability counter,
// debounced level and single-cycle press/release pulses registered with the level update.
module de1_soc_button_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic key_n,
   output logic level,
   output logic press_pulse,
   output logic release_pulse
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             meta_q;
   logic             sync_q;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta_q        <= 1'b0;
         sync_q        <= 1'b0;
         cnt           <= '0;
         level         <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
      end else begin
         meta_q        <= ~key_n;
         sync_q        <= meta_q;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         // Any return to the accepted level restarts the stability window.
         if (sync_q == level) begin
            cnt <= '0;
         end else if (cnt == CNT_MAX) begin
            level         <= sync_q;
            cnt           <= '0;
            press_pulse   <= sync_q;
            release_pulse <= ~sync_q;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/de1_soc_button_event_ctrl.sv
// Debounced button events queued in a FIFO behind an Avalon-MM slave with a level interrupt.
module de1_soc_button_event_ctrl
   import de1_soc_button_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int FIFO_DEPTH      = 8
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [3:0]  in_port,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        read_n,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        irq
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

   logic [NUM_KEYS-1:0] lvl;
   logic [NUM_KEYS-1:0] press_p;
   logic [NUM_KEYS-1:0] release_p;

   logic [NUM_KEYS-1:0] pending;
   logic [NUM_KEYS-1:0] pend_press;
   logic [NUM_KEYS-1:0] edges;
   logic [NUM_KEYS-1:0] gnt_mask;
   logic [1:0]          rr_ptr;
   logic [1:0]          cand;
   logic [1:0]          gnt_idx;
   logic                gnt_vld;

   event_t              mem [FIFO_DEPTH];
   event_t              head;
   logic [AW-1:0]       wr_ptr;
   logic [AW-1:0]       rd_ptr;
   logic [CW-1:0]       count;
   logic                full;
   logic                empty;

   logic [7:0]          irq_mask;
   logic                en;
   logic                ovf;

   logic                wr_en;
   logic                rd_en;
   logic                flush;
   logic                push;
   logic                pop;
   logic                do_write;
   logic                overflow;
   logic                ovf_clr;
   logic [31:0]         rd_mux;
   logic [31:0]         count_ext;
   logic                unused_wdata;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
         de1_soc_button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
         ) u_debounce (
            .clk          (clk),
            .reset_n      (reset_n),
            .key_n        (in_port[gi]),
            .level        (lvl[gi]),
            .press_pulse  (press_p[gi]),
            .release_pulse(release_p[gi])
         );
      end
   endgenerate

   assign wr_en    = chipselect & ~write_n;
   assign rd_en    = chipselect & ~read_n;
   assign flush    = wr_en && (address == REG_CTRL) && writedata[CTRL_FLUSH];
   assign ovf_clr  = wr_en && (address == REG_STATUS) && writedata[ST_OVF];
   assign edges    = en ? ((press_p & irq_mask[3:0]) | (release_p & irq_mask[7:4])) : '0;

   assign empty    = (count == '0);
   assign full     = (count == FULL_CNT);
   assign head     = mem[rd_ptr];
   assign push     = gnt_vld & ~flush;
   assign pop      = rd_en && (address == REG_EVENT) && !empty;
   // When full, a same-cycle pop frees the head slot the write pointer now aims at.
   assign do_write = push & (~full | pop);
   assign overflow = push & full & ~pop;
   assign irq      = ~empty;

   assign unused_wdata = ^{writedata[31:17], writedata[15:8]};

   // Round-robin search starting at rr_ptr.
   always_comb begin
      gnt_vld  = 1'b0;
      gnt_idx  = rr_ptr;
      cand     = rr_ptr;
      for (int k = 0; k < NUM_KEYS; k++) begin
         cand = rr_ptr + 2'(k);
         if (!gnt_vld && pending[cand]) begin
            gnt_vld = 1'b1;
            gnt_idx = cand;
         end
      end
      gnt_mask = gnt_vld ? (4'b0001 << gnt_idx) : 4'b0000;
   end

   always_comb begin
      rd_mux    = '0;
      count_ext = 32'(count);
      case (address)
         REG_EVENT: begin
            if (!empty) begin
               rd_mux[EV_VALID] = 1'b1;
               rd_mux[EV_PRESS] = head.press;
               rd_mux[1:0]      = head.idx;
            end
         end
         REG_STATUS: begin
            rd_mux[3:0]  = lvl;
            // A 16-deep full FIFO does not fit the 4-bit field; it reads as 15.
            rd_mux[11:8] = (count_ext > 32'd15) ? 4'hF : count_ext[3:0];
            rd_mux[ST_OVF] = ovf;
         end
         REG_MASK: rd_mux[7:0] = irq_mask;
         default:  rd_mux[CTRL_EN] = en;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pending    <= '0;
         pend_press <= '0;
         rr_ptr     <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         ovf        <= 1'b0;
         irq_mask   <= '0;
         en         <= 1'b0;
         readdata   <= '0;
      end else begin
         if (flush) begin
            pending <= '0;
         end else begin
            pending <= (pending & ~gnt_mask) | edges;
         end
         for (int i = 0; i < NUM_KEYS; i++) begin
            if (edges[i]) pend_press[i] <= press_p[i];
         end
         if (gnt_vld) rr_ptr <= gnt_idx + 2'd1;

         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (do_write) wr_ptr <= wr_ptr + 1'b1;
            if (pop)      rd_ptr <= rd_ptr + 1'b1;
            case ({do_write, pop})
               2'b10:   count <= count + 1'b1;
               2'b01:   count <= count - 1'b1;
               default: count <= count;
            endcase
         end

         if (overflow)     ovf <= 1'b1;
         else if (ovf_clr) ovf <= 1'b0;

         if (wr_en && (address == REG_MASK)) irq_mask <= writedata[7:0];
         if (wr_en && (address == REG_CTRL)) en       <= writedata[CTRL_EN];

         if (rd_en) readdata <= rd_mux;
      end
   end

   always_ff @(posedge clk) begin
      if (do_write) begin
         mem[wr_ptr].press <= pend_press[gnt_idx];
         mem[wr_ptr].idx   <= gnt_idx;
      end
   end

endmodule

// File: tb/tb_de1_soc_button_event_ctrl.sv
// Directed bench for de1_soc_button_event_ctrl with a short debounce window and a 4-deep FIFO.
module tb_de1_soc_button_event_ctrl;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [3:0]  in_port = 4'hF;
   logic [1:0]  address = 2'd0;
   logic        chipselect = 1'b0;
   logic        read_n = 1'b1;
   logic        write_n = 1'b1;
   logic [31:0] writedata = '0;
   logic [31:0] readdata;
   logic        irq;

   int vectors = 0;
   int miscompares = 0;

   de1_soc_button_event_ctrl #(
      .DEBOUNCE_CYCLES(4),
      .FIFO_DEPTH     (4)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_port   (in_port),
      .address   (address),
      .chipselect(chipselect),
      .read_n    (read_n),
      .write_n   (write_n),
      .writedata (writedata),
      .readdata  (readdata),
      .irq       (irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } reg_vec_t;

   reg_vec_t vecs [7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Bus tasks start and end on a falling edge.
   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1; writedata = '0;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
      address = a; chipselect = 1'b1; read_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chipselect = 1'b0; read_n = 1'b1;
      d = readdata;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0; in_port = 4'hF;
      chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   logic [31:0] rd;

   initial begin
      vecs[0] = '{2'd2, 32'h0000_00A5, 32'h0000_00A5};
      vecs[1] = '{2'd2, 32'hFFFF_FF3C, 32'h0000_003C};
      vecs[2] = '{2'd3, 32'hFFFF_FFFF, 32'h0000_0001};
      vecs[3] = '{2'd3, 32'h0000_0002, 32'h0000_0000};
      vecs[4] = '{2'd0, 32'hFFFF_FFFF, 32'h0000_0000};
      vecs[5] = '{2'd1, 32'hFFFF_FFFF, 32'h0000_0000};
      vecs[6] = '{2'd2, 32'h0000_0000, 32'h0000_0000};

      // Reset state
      wait_cyc(3);
      check("reset_readdata", readdata, 32'h0);
      check("reset_irq", {31'b0, irq}, 32'h0);
      reset_n = 1'b1;
      wait_cyc(1);
      bus_read(2'd1, rd);
      check("reset_status", rd, 32'h0);
      bus_read(2'd0, rd);
      check("reset_event", rd, 32'h0);

      // Register file vectors
      for (int i = 0; i < 7; i++) begin
         bus_write(vecs[i].addr, vecs[i].wdata);
         bus_read(vecs[i].addr, rd);
         check($sformatf("reg_vec%0d", i), rd, vecs[i].exp);
      end

      // Bouncy press on KEY0
      do_reset();
      bus_write(2'd2, 32'h01);
      bus_write(2'd3, 32'h01);
      in_port = 4'b1110; wait_cyc(2);
      in_port = 4'b1111; wait_cyc(2);
      in_port = 4'b1110; wait_cyc(15);
      check("bouncy_irq", {31'b0, irq}, 32'h1);
      bus_read(2'd1, rd);
      check("bouncy_status", rd, 32'h0000_0101);
      bus_read(2'd0, rd);
      check("bouncy_event", rd, 32'h8000_0004);
      check("bouncy_irq_after_read", {31'b0, irq}, 32'h0);
      bus_read(2'd0, rd);
      check("bouncy_empty_read", rd, 32'h0);
      in_port = 4'b1111; wait_cyc(12);
      bus_read(2'd1, rd);
      check("bouncy_release_masked", rd, 32'h0);

      // Simultaneous press on all keys
      do_reset();
      bus_write(2'd2, 32'h0F);
      bus_write(2'd3, 32'h01);
      in_port = 4'b0000; wait_cyc(15);
      bus_read(2'd1, rd);
      check("simul_status", rd, 32'h0000_040F);
      for (int i = 0; i < 4; i++) begin
         bus_read(2'd0, rd);
         check($sformatf("simul_event%0d", i), rd, 32'h8000_0004 + 32'(i));
      end
      bus_read(2'd0, rd);
      check("simul_empty", rd, 32'h0);
      check("simul_irq_low", {31'b0, irq}, 32'h0);

      // Mask filter: only release of KEY0 enabled
      do_reset();
      bus_write(2'd2, 32'h10);
      bus_write(2'd3, 32'h01);
      in_port = 4'b1110; wait_cyc(12);
      bus_read(2'd1, rd);
      check("mask_press_status", rd, 32'h0000_0001);
      in_port = 4'b1111; wait_cyc(12);
      bus_read(2'd1, rd);
      check("mask_release_status", rd, 32'h0000_0100);
      bus_read(2'd0, rd);
      check("mask_event", rd, 32'h8000_0000);

      // Overflow: four presses fill the FIFO, the KEY0 release is dropped
      do_reset();
      bus_write(2'd2, 32'hFF);
      bus_write(2'd3, 32'h01);
      in_port = 4'b0000; wait_cyc(15);
      in_port = 4'b0001; wait_cyc(12);
      bus_read(2'd1, rd);
      check("ovf_status", rd, 32'h0001_040E);
      bus_write(2'd1, 32'h0001_0000);
      bus_read(2'd1, rd);
      check("ovf_cleared", rd, 32'h0000_040E);
      bus_read(2'd0, rd);
      check("ovf_head", rd, 32'h8000_0004);
      bus_read(2'd1, rd);
      check("ovf_level_after_pop", rd, 32'h0000_030E);

      // Flush lands on the first grant cycle while three more are pending
      do_reset();
      bus_write(2'd2, 32'h0F);
      bus_write(2'd3, 32'h01);
      in_port = 4'b0000;
      repeat (7) @(posedge clk);
      @(negedge clk);
      bus_write(2'd3, 32'h03);
      check("flush_irq", {31'b0, irq}, 32'h0);
      wait_cyc(10);
      bus_read(2'd1, rd);
      check("flush_status", rd, 32'h0000_000F);
      check("flush_irq_later", {31'b0, irq}, 32'h0);

      // Reset pulse in the middle of a debounce window
      do_reset();
      bus_write(2'd2, 32'h01);
      bus_write(2'd3, 32'h01);
      in_port = 4'b1110;
      repeat (4) @(posedge clk);
      #1 reset_n = 1'b0;
      in_port = 4'b1111;
      wait_cyc(2);
      check("midreset_readdata", readdata, 32'h0);
      check("midreset_irq", {31'b0, irq}, 32'h0);
      reset_n = 1'b1;
      wait_cyc(12);
      bus_read(2'd1, rd);
      check("midreset_status", rd, 32'h0);
      bus_read(2'd0, rd);
      check("midreset_event", rd, 32'h0);
      bus_read(2'd2, rd);
      check("midreset_mask", rd, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
